// File: rtl/apb4_mst_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb4_mst_pkg
// Brief    : Shared state encoding and constants for the APB4 initiator.
// Revision : 1.0 - initial release
// ============================================================================
package apb4_mst_pkg;

    localparam int c_apb4_pprot_width = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb4_state_e;

endpackage
`default_nettype wire

// File: rtl/apb4_mst_tmo.sv
`default_nettype none
// ============================================================================
// Module   : apb4_mst_tmo
// Brief    : Loadable saturating PREADY timeout counter; limit 0 disables.
// Revision : 1.0 - initial release
// ============================================================================
module apb4_mst_tmo #(
    parameter int TMO_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clr,
    input  logic                 i_load,
    input  logic                 i_en,
    input  logic [TMO_WIDTH-1:0] i_limit,
    output logic                 o_expire
);

    localparam logic [TMO_WIDTH-1:0] c_one = {{(TMO_WIDTH-1){1'b0}}, 1'b1};

    logic [TMO_WIDTH-1:0] r_cnt;
    logic [TMO_WIDTH-1:0] r_limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_limit <= '0;
        end else begin
            if (i_load) begin
                r_limit <= i_limit;
            end
            // Saturate at all-ones so a disabled timeout never wraps into a match.
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_en && (r_cnt != '1)) begin
                r_cnt <= r_cnt + c_one;
            end
        end
    end

    assign o_expire = (r_limit != '0) && (r_cnt == (r_limit - c_one));

endmodule
`default_nettype wire

// File: rtl/dffer.sv
`default_nettype none
// ============================================================================
// Module   : dffer
// Brief    : Enable flop bank with asynchronous active-low reset to zero.
// Revision : 1.0 - initial release
// ============================================================================
module dffer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb4_mst.sv
`default_nettype none
// ============================================================================
// Module   : apb4_mst
// Brief    : APB4 initiator bridging a valid/ready command/response stream.
// Revision : 1.0 - initial release
// ============================================================================
module apb4_mst
    import apb4_mst_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TMO_WIDTH  = 8
) (
    input  logic                          apb4_pclk,
    input  logic                          apb4_presetn,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic                          cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]         cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]         cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]       cmd_strb_i,
    input  logic [c_apb4_pprot_width-1:0] cmd_prot_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
    output logic                          rsp_err_o,
    output logic                          rsp_tmo_o,
    input  logic [TMO_WIDTH-1:0]          tmo_cyc_i,
    output logic                          busy_o,
    output logic [ADDR_WIDTH-1:0]         apb4_paddr,
    output logic [c_apb4_pprot_width-1:0] apb4_pprot,
    output logic                          apb4_psel,
    output logic                          apb4_penable,
    output logic                          apb4_pwrite,
    output logic [DATA_WIDTH-1:0]         apb4_pwdata,
    output logic [DATA_WIDTH/8-1:0]       apb4_pstrb,
    input  logic                          apb4_pready,
    input  logic [DATA_WIDTH-1:0]         apb4_prdata,
    input  logic                          apb4_pslverr
);

    localparam int c_strb_width = DATA_WIDTH / 8;
    localparam int c_ctl_width  = 1 + ADDR_WIDTH + c_apb4_pprot_width;
    localparam int c_rsp_width  = DATA_WIDTH + 2;

    apb4_state_e r_state;
    apb4_state_e w_state_nxt;
    logic        r_psel;
    logic        r_penable;
    logic        r_rsp_valid;
    logic        r_cmd_ready;
    logic        w_psel_nxt;
    logic        w_penable_nxt;
    logic        w_rsp_valid_nxt;
    logic        w_cmd_ready_nxt;
    logic        w_cmd_hs;
    logic        w_rsp_hs;
    logic        w_expire;
    logic        w_done;

    logic [c_ctl_width-1:0]  w_ctl_d;
    logic [c_ctl_width-1:0]  w_ctl_q;
    logic [c_strb_width-1:0] w_strb_d;
    logic [c_rsp_width-1:0]  w_rsp_d;
    logic [c_rsp_width-1:0]  w_rsp_q;

    assign w_cmd_hs = cmd_valid_i && r_cmd_ready;
    assign w_rsp_hs = r_rsp_valid && rsp_ready_i;
    assign w_done   = (r_state == ACCESS) && (apb4_pready || w_expire);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_cmd_hs) w_state_nxt = SETUP;
            SETUP:   w_state_nxt = ACCESS;
            ACCESS:  if (apb4_pready || w_expire) w_state_nxt = RESP;
            RESP:    if (w_rsp_hs) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        // Handshake/bus strobes are registered from the next state so reset forces them low.
        w_psel_nxt      = (w_state_nxt == SETUP) || (w_state_nxt == ACCESS);
        w_penable_nxt   = (w_state_nxt == ACCESS);
        w_rsp_valid_nxt = (w_state_nxt == RESP);
        w_cmd_ready_nxt = (w_state_nxt == IDLE);
    end

    always_ff @(posedge apb4_pclk or negedge apb4_presetn) begin
        if (!apb4_presetn) begin
            r_state     <= IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
        end
    end

    assign w_ctl_d  = {cmd_write_i, cmd_addr_i, cmd_prot_i};
    assign w_strb_d = cmd_write_i ? cmd_strb_i : '0;

    dffer #(.WIDTH(c_ctl_width)) u_ctl_reg (
        .clk   (apb4_pclk),
        .rst_n (apb4_presetn),
        .i_en  (w_cmd_hs),
        .i_d   (w_ctl_d),
        .o_q   (w_ctl_q)
    );

    // Write data only loads on writes so PWDATA stays quiet across reads.
    dffer #(.WIDTH(DATA_WIDTH)) u_wdata_reg (
        .clk   (apb4_pclk),
        .rst_n (apb4_presetn),
        .i_en  (w_cmd_hs && cmd_write_i),
        .i_d   (cmd_wdata_i),
        .o_q   (apb4_pwdata)
    );

    dffer #(.WIDTH(c_strb_width)) u_strb_reg (
        .clk   (apb4_pclk),
        .rst_n (apb4_presetn),
        .i_en  (w_cmd_hs),
        .i_d   (w_strb_d),
        .o_q   (apb4_pstrb)
    );

    assign w_rsp_d = {
        (apb4_pready && !apb4_pwrite) ? apb4_prdata : {DATA_WIDTH{1'b0}},
        apb4_pready ? apb4_pslverr : 1'b1,
        !apb4_pready
    };

    dffer #(.WIDTH(c_rsp_width)) u_rsp_reg (
        .clk   (apb4_pclk),
        .rst_n (apb4_presetn),
        .i_en  (w_done),
        .i_d   (w_rsp_d),
        .o_q   (w_rsp_q)
    );

    apb4_mst_tmo #(.TMO_WIDTH(TMO_WIDTH)) u_tmo (
        .clk      (apb4_pclk),
        .rst_n    (apb4_presetn),
        .i_clr    (w_cmd_hs),
        .i_load   (w_cmd_hs),
        .i_en     (r_state == ACCESS),
        .i_limit  (tmo_cyc_i),
        .o_expire (w_expire)
    );

    assign {apb4_pwrite, apb4_paddr, apb4_pprot} = w_ctl_q;
    assign {rsp_rdata_o, rsp_err_o, rsp_tmo_o}   = w_rsp_q;

    assign cmd_ready_o  = r_cmd_ready;
    assign rsp_valid_o  = r_rsp_valid;
    assign apb4_psel    = r_psel;
    assign apb4_penable = r_penable;
    assign busy_o       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_apb4_mst.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb4_mst
// Brief    : Directed self-checking bench for the APB4 initiator.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_apb4_mst;

    logic        clk = 1'b0;
    logic        presetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic [2:0]  cmd_prot = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_tmo;
    logic [7:0]  tmo_cyc = '0;
    logic        busy;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready = 1'b1;
    logic [31:0] prdata = '0;
    logic        pslverr = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    apb4_mst dut (
        .apb4_pclk    (clk),
        .apb4_presetn (presetn),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_write_i  (cmd_write),
        .cmd_addr_i   (cmd_addr),
        .cmd_wdata_i  (cmd_wdata),
        .cmd_strb_i   (cmd_strb),
        .cmd_prot_i   (cmd_prot),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .rsp_tmo_o    (rsp_tmo),
        .tmo_cyc_i    (tmo_cyc),
        .busy_o       (busy),
        .apb4_paddr   (paddr),
        .apb4_pprot   (pprot),
        .apb4_psel    (psel),
        .apb4_penable (penable),
        .apb4_pwrite  (pwrite),
        .apb4_pwdata  (pwdata),
        .apb4_pstrb   (pstrb),
        .apb4_pready  (pready),
        .apb4_prdata  (prdata),
        .apb4_pslverr (pslverr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command; returns in the cycle after the handshake edge (SETUP).
    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = 3'd2;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        #13;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
        checks++; if ({psel, penable, rsp_valid, busy} !== 4'b0) begin errors++; $display("FAIL reset_ctl: got %b expected 0000", {psel, penable, rsp_valid, busy}); end
        checks++; if ({paddr, pwdata, pstrb, pwrite} !== '0) begin errors++; $display("FAIL reset_bus: got addr %h wdata %h expected 0", paddr, pwdata); end
        presetn = 1'b1;
        tick(); tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_write();
        pready = 1'b1;
        send_cmd(1'b1, 32'h08, 32'hA5A5_0001, 4'hF);
        checks++; if ({psel, penable, cmd_ready} !== 3'b100) begin errors++; $display("FAIL wr_setup: got psel/pen/rdy %b expected 100", {psel, penable, cmd_ready}); end
        tick();
        checks++; if ({psel, penable} !== 2'b11) begin errors++; $display("FAIL wr_access: got %b expected 11", {psel, penable}); end
        checks++; if (pwdata !== 32'hA5A5_0001 || paddr !== 32'h08 || pstrb !== 4'hF || pwrite !== 1'b1 || pprot !== 3'd2) begin
            errors++; $display("FAIL wr_bus: got data %h addr %h strb %h expected A5A50001 08 F", pwdata, paddr, pstrb); end
        tick();
        checks++; if ({rsp_valid, psel, penable} !== 3'b100) begin errors++; $display("FAIL wr_resp: got %b expected 100", {rsp_valid, psel, penable}); end
        checks++; if (rsp_err !== 1'b0 || rsp_tmo !== 1'b0 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL wr_rsp_fields: got err %b tmo %b rdata %h expected 0 0 0", rsp_err, rsp_tmo, rsp_rdata); end
        tick();
        checks++; if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin errors++; $display("FAIL wr_done: got %b expected 010", {rsp_valid, cmd_ready, busy}); end
    endtask

    task automatic test_read_wait();
        int access_cnt = 0;
        pready = 1'b0;
        prdata = 32'h1234_5678;
        send_cmd(1'b0, 32'h0C, 32'hFFFF_FFFF, 4'hF);
        tick();
        for (int k = 0; k < 4; k++) begin
            if (penable === 1'b1 && paddr === 32'h0C) access_cnt++;
            if (k == 3) pready = 1'b1;
            tick();
        end
        checks++; if (access_cnt !== 4) begin errors++; $display("FAIL rd_access_len: got %0d expected 4", access_cnt); end
        checks++; if ({rsp_valid, penable} !== 2'b10) begin errors++; $display("FAIL rd_resp: got %b expected 10", {rsp_valid, penable}); end
        checks++; if (rsp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_rdata: got %h expected 12345678", rsp_rdata); end
        checks++; if (pstrb !== 4'h0 || pwrite !== 1'b0 || pwdata !== 32'hA5A5_0001) begin
            errors++; $display("FAIL rd_bus: got strb %h write %b wdata %h expected 0 0 A5A50001", pstrb, pwrite, pwdata); end
        tick();
    endtask

    task automatic test_slverr();
        pready = 1'b1; pslverr = 1'b1;
        send_cmd(1'b1, 32'h10, 32'h0000_0001, 4'h3);
        tick(); tick();
        pslverr = 1'b0;
        checks++; if ({rsp_valid, rsp_err, rsp_tmo} !== 3'b110) begin errors++; $display("FAIL slverr: got valid/err/tmo %b expected 110", {rsp_valid, rsp_err, rsp_tmo}); end
        tick();
    endtask

    task automatic test_timeout();
        int acc;
        logic seen;
        pready = 1'b0; prdata = 32'hDEAD_BEEF;
        foreach (acc_lims[i]) begin
            tmo_cyc = acc_lims[i];
            send_cmd(1'b0, 32'h14, 32'h0, 4'hF);
            acc = 0; seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                tick();
                if (rsp_valid === 1'b1) seen = 1'b1;
                else if (penable === 1'b1) acc++;
            end
            checks++; if (!seen || acc != int'(acc_lims[i])) begin errors++; $display("FAIL tmo_len_%0d: got %0d access cycles (resp %b) expected %0d", acc_lims[i], acc, seen, acc_lims[i]); end
            checks++; if ({psel, rsp_err, rsp_tmo} !== 3'b011 || rsp_rdata !== 32'h0) begin
                errors++; $display("FAIL tmo_fields_%0d: got psel/err/tmo %b rdata %h expected 011 0", acc_lims[i], {psel, rsp_err, rsp_tmo}, rsp_rdata); end
            tick();
        end
        tmo_cyc = 8'd0;
        send_cmd(1'b0, 32'h18, 32'h0, 4'hF);
        seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0 || penable !== 1'b1) begin errors++; $display("FAIL tmo_disabled: got resp %b penable %b expected 0 1", seen, penable); end
        pready = 1'b1; prdata = 32'hCAFE_0000;
        tick();
        checks++; if ({rsp_valid, rsp_tmo, rsp_err} !== 3'b100 || rsp_rdata !== 32'hCAFE_0000) begin
            errors++; $display("FAIL tmo_disabled_done: got %b rdata %h expected 100 CAFE0000", {rsp_valid, rsp_tmo, rsp_err}, rsp_rdata); end
        tick();
    endtask

    logic [7:0] acc_lims [2] = '{8'd4, 8'd1};

    task automatic test_back_to_back();
        int bad = 0;
        pready = 1'b1; rsp_ready = 1'b0;
        send_cmd(1'b1, 32'h20, 32'h0000_0011, 4'hF);
        cmd_write = 1'b1; cmd_addr = 32'h24; cmd_wdata = 32'h0000_0022; cmd_strb = 4'h1;
        cmd_valid = 1'b1;
        tick(); tick();
        pslverr = 1'b1; prdata = 32'h5555_5555;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || psel !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) bad++;
            tick();
        end
        pslverr = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_hold: got %0d unstable cycles expected 0", bad); end
        rsp_ready = 1'b1;
        tick();
        checks++; if ({rsp_valid, cmd_ready, psel} !== 3'b010) begin errors++; $display("FAIL b2b_idle: got %b expected 010", {rsp_valid, cmd_ready, psel}); end
        tick();
        cmd_valid = 1'b0;
        checks++; if (psel !== 1'b1 || paddr !== 32'h24 || pwdata !== 32'h22) begin
            errors++; $display("FAIL b2b_second: got psel %b addr %h data %h expected 1 24 22", psel, paddr, pwdata); end
        tick(); tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_resp: got %b expected 1", rsp_valid); end
        tick();
    endtask

    task automatic test_reset_mid();
        pready = 1'b0; tmo_cyc = 8'd0;
        send_cmd(1'b1, 32'h30, 32'h0000_0033, 4'hF);
        tick();
        checks++; if (penable !== 1'b1) begin errors++; $display("FAIL mid_access: got %b expected 1", penable); end
        #2 presetn = 1'b0;
        #1;
        checks++; if ({psel, penable, rsp_valid, busy} !== 4'b0) begin errors++; $display("FAIL mid_async_clear: got %b expected 0000", {psel, penable, rsp_valid, busy}); end
        pready = 1'b1;
        tick();
        presetn = 1'b1;
        tick(); tick();
        checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL mid_recover: got rdy/valid %b expected 10", {cmd_ready, rsp_valid}); end
        send_cmd(1'b1, 32'h34, 32'h0000_0044, 4'hF);
        tick(); tick();
        checks++; if ({rsp_valid, rsp_err} !== 2'b10 || paddr !== 32'h34) begin
            errors++; $display("FAIL mid_next_xfer: got valid/err %b addr %h expected 10 34", {rsp_valid, rsp_err}, paddr); end
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb4_mst.md
Name: apb4_mst

Overview:
- APB4 initiator: turns a valid/ready command stream into single APB4 transfers and returns each result on a valid/ready response stream.
- Drives the register slaves of the peripheral subsystem (tmr and siblings) from a simple command source: a debug bridge, DMA-lite, or a bus-to-APB shim.
- Handles one transfer at a time, with a programmable-length PREADY timeout so a hung slave cannot stall the source.

Parameters:
- ADDR_WIDTH, 32, width of apb4_paddr and cmd_addr_i.
- DATA_WIDTH, 32, width of the wdata/rdata paths; must be 8, 16 or 32.
- TMO_WIDTH, 8, width of the timeout counter and of tmo_cyc_i.

Ports:
- apb4_pclk  in  1  clock
- apb4_presetn  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&&ready
- cmd_write_i  in  1  1=write, 0=read
- cmd_addr_i  in  ADDR_WIDTH  target address
- cmd_wdata_i  in  DATA_WIDTH  write data
- cmd_strb_i  in  DATA_WIDTH/8  write byte strobes
- cmd_prot_i  in  3  PPROT value
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&&ready
- rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes or on timeout)
- rsp_err_o  out  1  PSLVERR seen or timeout
- rsp_tmo_o  out  1  transfer aborted by timeout
- tmo_cyc_i  in  TMO_WIDTH  max ACCESS cycles without PREADY; 0 = timeout disabled
- busy_o  out  1  state != IDLE
- apb4_paddr  out  ADDR_WIDTH
- apb4_pprot  out  3
- apb4_psel  out  1
- apb4_penable  out  1
- apb4_pwrite  out  1
- apb4_pwdata  out  DATA_WIDTH
- apb4_pstrb  out  DATA_WIDTH/8
- apb4_pready  in  1
- apb4_prdata  in  DATA_WIDTH
- apb4_pslverr  in  1

Behaviour:
- Reset values: every output is 0; state = IDLE; timeout counter = 0.
- FSM states are IDLE, SETUP, ACCESS and RESP.
- IDLE:
  - cmd_ready_o=1; psel=0, penable=0.
  - On a cmd handshake: register addr, write, wdata, prot and strb (strb forced to 0 for reads), then go to SETUP.
- SETUP (exactly 1 cycle):
  - psel=1, penable=0; address and control come from the registered command.
  - Always moves to ACCESS.
- ACCESS:
  - psel=1, penable=1; the timeout counter increments each cycle in this state.
  - pready=1 ends the transfer and goes to RESP:
    - capture prdata for reads only, 0 for writes;
    - rsp_err = pslverr; rsp_tmo = 0.
  - Timeout: if tmo_cyc_i!=0 and the counter == tmo_cyc_i-1 while pready=0:
    - go to RESP with rsp_err=1, rsp_tmo=1, rdata=0;
    - psel and penable drop on the next cycle.
  - pready wins over timeout when both occur in the same cycle.
- RESP:
  - rsp_valid_o=1; psel=0, penable=0.
  - Response fields are held stable until rsp_ready_i; the handshake returns to IDLE.
  - rsp_valid is never withdrawn without a handshake.
- Latency: command accepted in cycle N → psel in N+1 → penable in N+2 → with pready in N+2, rsp_valid in N+3. Minimum 4 cycles per transfer.
- cmd_ready_o is 0 outside IDLE; a command presented during a transfer waits.
- paddr, pwrite, pwdata, pstrb and pprot:
  - stay constant from SETUP through the last ACCESS cycle;
  - hold their last value in IDLE and RESP; pwdata is not toggled on reads.
- Timeout counter:
  - cleared on entry to SETUP;
  - saturates and never wraps;
  - tmo_cyc_i is sampled on entry to SETUP, so changes mid-transfer have no effect.
- tmo_cyc_i=1: the transfer times out after 1 ACCESS cycle unless pready is already high in that cycle.
- Reset asserted mid-transfer: psel, penable and rsp_valid clear asynchronously; the FSM returns to IDLE; no response is emitted for the aborted command.

Decomposition:
- Shared define/package file apb4_mst_define.svh holds:
  - the state enum: IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3;
  - the APB4_PPROT width constant.
- Command/response registers use the existing dffer.
- One natural sub-module, apb4_mst_tmo: loadable saturating timeout counter with clear, enable, limit input and expire output.

Test Plan:
- Write 0xA5A5_0001 to addr 0x08, strb 0xF, pready tied 1 → psel at N+1, penable at N+2, pwdata=0xA5A5_0001, rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
- Read addr 0x0C; slave holds pready=0 for 3 ACCESS cycles, then returns prdata=0x1234_5678 → ACCESS lasts 4 cycles, paddr stable throughout, rsp_rdata=0x1234_5678, pstrb=0.
- Write with pslverr=1 alongside pready → rsp_err=1, rsp_tmo=0.
- tmo_cyc_i=4, pready stuck at 0 → exactly 4 ACCESS cycles, then psel=0, rsp_err=1, rsp_tmo=1, rsp_rdata=0; tmo_cyc_i=0 with pready stuck → no response after 300 cycles.
- Back-to-back commands with rsp_ready held 0 for 5 cycles → response fields stable, cmd_ready=0 until the response handshake, second command's psel appears 2 cycles after the handshake.
- Assert apb4_presetn during ACCESS → psel, penable and rsp_valid drop immediately; after release cmd_ready=1 and the next transfer completes normally.
